// File: rtl/shift_add_mul8.sv
// Sequential 8x8 unsigned shift-and-add multiplier wrapped around an external 8-bit adder.
// Optional build macro MUL_ZERO_BYPASS_EN: a zero operand skips RUN and completes in one cycle.
module shift_add_mul8 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    // The external adder is fixed at 8 bits, so any other width is a build error.
    generate
        if (WIDTH != 8) begin : g_width_check
            $error("shift_add_mul8: WIDTH must be 8 to match the external adder");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     m_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   product_q;

    logic                 load;
    logic                 step;
    logic                 finish;
    logic                 bypass;

`ifdef MUL_ZERO_BYPASS_EN
    logic                 zero_op;
    assign zero_op = (multiplicand == '0) || (multiplier == '0);
`endif

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        bypass  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = S_RUN;
`ifdef MUL_ZERO_BYPASS_EN
                    if (zero_op) begin
                        load    = 1'b0;
                        bypass  = 1'b1;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (cnt_q == LAST_ITER) begin
                    finish  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every datapath register is reset, so add_a/add_b are defined (zero) straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            m_q   <= multiplicand;
            hi_q  <= '0;
            lo_q  <= multiplier;
            cnt_q <= '0;
        end else if (step) begin
            // The carry drops straight into HI[7]; the separate C bit is always 0 after the shift.
            hi_q  <= {add_cout, add_sum[WIDTH-1:1]};
            lo_q  <= {add_sum[0], lo_q[WIDTH-1:1]};
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Product captures the post-shift value on the final RUN edge and holds until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product_q <= '0;
        end else if (finish) begin
            product_q <= {add_cout, add_sum, lo_q[WIDTH-1:1]};
        end else if (bypass) begin
            product_q <= '0;
        end
    end

    assign add_a   = hi_q;
    assign add_b   = lo_q[0] ? m_q : '0;
    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mul8.sv
// Self-checking bench for shift_add_mul8: models the external adder and compares against plain a*b.
module tb_shift_add_mul8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic [7:0]  add_sum;
    logic        add_cout;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_product = 16'h0000;
    bit          saw_cout;

    shift_add_mul8 #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_sum      (add_sum),
        .add_cout     (add_cout)
    );

    // The team's combinational ripple-carry adder, modelled behaviourally.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_bypass(input logic [7:0] a, input logic [7:0] b);
`ifdef MUL_ZERO_BYPASS_EN
        return (a == 8'd0) || (b == 8'd0);
`else
        return 1'b0;
`endif
    endfunction

    // One full operation; optionally pulses start with other operands at RUN cycle inject+1.
    task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input int inject,
                          input logic [7:0] ia, input logic [7:0] ib);
        logic [15:0] prev;
        prev = exp_product;
        saw_cout = 1'b0;
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (is_bypass(a, b)) begin
            check("bypass_done", done, 1);
            check("bypass_busy", busy, 0);
            check("bypass_product", product, 0);
            exp_product = 16'h0000;
        end else begin
            for (int i = 1; i <= 8; i++) begin
                if (i > 1) @(negedge clk);
                if (add_cout) saw_cout = 1'b1;
                check($sformatf("run_busy_%0d", i), busy, 1);
                check($sformatf("run_done_%0d", i), done, 0);
                check($sformatf("run_hold_%0d", i), product, prev);
                if (inject != 0 && i == inject) begin
                    multiplicand = ia;
                    multiplier   = ib;
                    start        = 1'b1;
                end else begin
                    start = 1'b0;
                end
            end
            start = 1'b0;
            @(negedge clk);
            exp_product = a * b;
            check("done_pulse", done, 1);
            check("done_busy", busy, 0);
            check($sformatf("product_%0dx%0d", a, b), product, exp_product);
        end
        @(negedge clk);
        check("after_done", done, 0);
        check("after_busy", busy, 0);
        check("after_product", product, exp_product);
    endtask

    initial begin
        int ndone;
        int t_first;
        int t_second;
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = 8'd0;
        multiplier   = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_product", product, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        rst_n = 1'b1;

        do_mul(8'd3, 8'd5, 0, 8'd0, 8'd0);
        do_mul(8'd255, 8'd255, 0, 8'd0, 8'd0);
        check("cout_seen", saw_cout, 1);
        do_mul(8'h81, 8'h81, 0, 8'd0, 8'd0);
        do_mul(8'h01, 8'h01, 0, 8'd0, 8'd0);

        // Start pulsed mid-RUN must be ignored; no extra completion follows.
        do_mul(8'd3, 8'd5, 3, 8'd77, 8'd99);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no_second_done", ndone, 0);
        check("ignored_product", product, 16'h000F);

        // Reset asserted mid-RUN abandons the operation.
        @(negedge clk);
        multiplicand = 8'd200;
        multiplier   = 8'd100;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_product", product, 0);
        check("midrst_add_a", add_a, 0);
        check("midrst_add_b", add_b, 0);
        exp_product = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("midrst_quiet", ndone, 0);
        do_mul(8'd200, 8'd100, 0, 8'd0, 8'd0);

        do_mul(8'd0, 8'd200, 0, 8'd0, 8'd0);
        do_mul(8'd200, 8'd0, 0, 8'd0, 8'd0);

        for (int n = 0; n < 20; n++) begin
            do_mul(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 8'd0, 8'd0);
        end

        // start held high: completions every 10 cycles.
        @(negedge clk);
        multiplicand = 8'd7;
        multiplier   = 8'd9;
        start        = 1'b1;
        ndone    = 0;
        t_first  = 0;
        t_second = 0;
        for (int i = 1; i <= 40 && ndone < 2; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) t_first = i;
                else begin
                    t_second = i;
                    start    = 1'b0;
                end
                check("b2b_product", product, 16'd63);
            end
        end
        start = 1'b0;
        check("b2b_count", ndone, 2);
        check("b2b_period", t_second - t_first, 10);
        exp_product = 16'd63;
        repeat (12) @(negedge clk);
        check("b2b_idle", busy, 0);
        check("b2b_final", product, exp_product);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
